spi_frame_engine: RTL and testbench
===================================

SPI_FRAME_ENGINE -- requirements
Module: spi_frame_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk cycles (legal values 2..255).
REQ-002 SHALL have parameter CS_GAP, default 4, meaning the clk cycles cs_b stays high between frames (legal values 1..255).
REQ-003 SHALL have port clk, input, 1 bit, system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, one-cycle trigger pulse from the host trigger endpoint.
REQ-006 SHALL have port num_frames, input, 8 bits; frames per burst = num_frames+1.
REQ-007 SHALL have port cmd_word, input, 16 bits, command shifted out in every frame.
REQ-008 SHALL have port miso, input, 1 bit, sensor serial data.
REQ-009 SHALL have port fifo_full, input, 1 bit, downstream FIFO full flag.
REQ-010 SHALL have port sclk, output, 1 bit, SPI clock, idle low.
REQ-011 SHALL have port cs_b, output, 1 bit, active-low chip select.
REQ-012 SHALL have port mosi, output, 1 bit, serial command data, MSB first.
REQ-013 SHALL have port result_data, output, 32 bits: {frame_idx[7:0], 8'h00, rx_word[15:0]}.
REQ-014 SHALL have port result_wr_en, output, 1 bit, one-cycle FIFO write strobe.
REQ-015 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit, one-cycle pulse at burst completion.
REQ-017 SHALL have port overflow, output, 1 bit, sticky flag set when a result is dropped.

Function
REQ-018 SHALL implement the states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP and DONE.
REQ-019 SHALL, when start=1 in IDLE, latch cmd_word and num_frames, clear frame_idx, and enter CS_SETUP on the next cycle.
REQ-020 SHALL ignore start in every state except IDLE; the latched values SHALL NOT change mid-burst.
REQ-021 SHALL, in CS_SETUP, drive cs_b=0 and mosi=cmd[15] for CLK_DIV cycles, then enter SHIFT.
REQ-022 SHALL, in SHIFT, produce 16 SCLK periods of 2*CLK_DIV cycles each, SPI mode 0: sclk low for the first CLK_DIV cycles of a period, then high for the next CLK_DIV cycles.
REQ-023 SHALL sample miso into rx_word (MSB first) on the clk cycle in which sclk goes 0->1.
REQ-024 SHALL update mosi to the next bit on the clk cycle in which sclk goes 1->0.
REQ-025 SHALL, after the 16th falling edge, enter CS_HOLD with cs_b=0 and sclk=0 for CLK_DIV cycles.
REQ-026 SHALL, on leaving CS_HOLD, set cs_b=1 and pulse result_wr_en for one cycle with result_data valid in that cycle, provided fifo_full=0.
REQ-027 SHALL, if fifo_full=1 in that cycle, suppress result_wr_en and set overflow=1 (sticky until reset).
REQ-028 SHALL hold cs_b=1 in GAP for CS_GAP cycles, then enter CS_SETUP with frame_idx incremented if frame_idx < latched num_frames; otherwise enter DONE.
REQ-029 SHALL, in DONE, pulse done for one cycle and return to IDLE on the next cycle.
REQ-030 SHALL have a frame period of 34*CLK_DIV+CS_GAP cycles (140 cycles at default parameters).
REQ-031 SHALL let frame_idx wrap naturally: num_frames=255 yields 256 frames, indices 0..255.

Reset
REQ-032 SHALL, while reset=1, force state=IDLE, sclk=0, cs_b=1, mosi=0, result_data=0, result_wr_en=0, busy=0, done=0, overflow=0, and clear frame_idx and the divider counters.
REQ-033 SHALL, on reset asserted mid-frame, abort the frame in the next cycle with no result_wr_en and no done pulse.
REQ-034 SHALL let reset take priority over a start pulse in the same cycle.

Configuration
REQ-035 SHALL, with SPI_LOOPBACK_EN defined, feed mosi back internally as the miso sample source and ignore the miso port.
REQ-036 SHALL, without SPI_LOOPBACK_EN defined, sample the miso port; no loopback logic is present.

Verification
REQ-037 SHALL cover: SPI_LOOPBACK_EN, num_frames=0, cmd_word=16'hA5C3, start -> one result_wr_en with result_data=32'h0000A5C3, done 140 cycles after the first cs_b fall.
REQ-038 SHALL cover: miso driven by a sensor model returning 16'h1234, num_frames=31 -> 32 writes, last one 32'h1F001234, 32 cs_b low windows.
REQ-039 SHALL cover: a start pulse mid-burst with num_frames=5 -> ignored; exactly 6 writes, single done pulse.
REQ-040 SHALL cover: fifo_full=1 during frame 2 of a 4-frame burst -> 3 writes (indices 0,1,3) and overflow=1 held until reset.
REQ-041 SHALL cover: reset pulsed in SHIFT -> within 1 cycle cs_b=1, sclk=0, busy=0; no write and no done pulse.
REQ-042 SHALL cover: CLK_DIV=2 with cmd_word=16'h8001 -> sclk period 4 cycles, mosi high only for bits 15 and 0.

Source files
------------

// File: rtl/spi_frame_engine.sv
// SPI mode-0 burst engine: shifts cmd_word out num_frames+1 times and writes each received word to a FIFO.
// Define SPI_LOOPBACK_EN to sample mosi internally instead of the miso port.
module spi_frame_engine #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_frames,
  input  logic [15:0] cmd_word,
  input  logic        miso,
  input  logic        fifo_full,
  output logic        sclk,
  output logic        cs_b,
  output logic        mosi,
  output logic [31:0] result_data,
  output logic        result_wr_en,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] cmd_lat;
  logic [15:0] cmd_sh;
  logic [15:0] rx_word;
  logic [7:0]  nf_lat;
  logic [7:0]  frame_idx;
  logic        sample;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample      = mosi;
`else
  assign sample = miso;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      bit_cnt      <= 4'd0;
      cmd_lat      <= 16'd0;
      cmd_sh       <= 16'd0;
      rx_word      <= 16'd0;
      nf_lat       <= 8'd0;
      frame_idx    <= 8'd0;
      sclk         <= 1'b0;
      cs_b         <= 1'b1;
      mosi         <= 1'b0;
      result_data  <= 32'd0;
      result_wr_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_wr_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cmd_lat   <= cmd_word;
            cmd_sh    <= cmd_word;
            nf_lat    <= num_frames;
            frame_idx <= 8'd0;
            mosi      <= cmd_word[15];
            cs_b      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= 8'd0;
            state     <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= 8'd0;
            bit_cnt <= 4'd0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (!sclk) begin
              sclk    <= 1'b1;
              rx_word <= {rx_word[14:0], sample};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= CS_HOLD;
              end else begin
                // next command bit goes out on the falling edge
                bit_cnt <= bit_cnt + 4'd1;
                cmd_sh  <= {cmd_sh[14:0], 1'b0};
                mosi    <= cmd_sh[14];
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CS_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt         <= 8'd0;
            cs_b        <= 1'b1;
            mosi        <= 1'b0;
            result_data <= {frame_idx, 8'h00, rx_word};
            if (fifo_full) overflow     <= 1'b1;
            else           result_wr_en <= 1'b1;
            state <= GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 8'd0;
            if (frame_idx < nf_lat) begin
              frame_idx <= frame_idx + 8'd1;
              cmd_sh    <= cmd_lat;
              mosi      <= cmd_lat[15];
              cs_b      <= 1'b0;
              state     <= CS_SETUP;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Bench for spi_frame_engine: two instances (CLK_DIV=4/CS_GAP=4 and CLK_DIV=2/CS_GAP=3) checked every cycle
// against a timeline model derived from frame-period arithmetic, plus directed literal checks.
module tb_spi_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start[2];
  logic [7:0]  num_frames[2];
  logic [15:0] cmd_word[2];
  logic        miso[2];
  logic        fifo_full[2];
  logic        sclk[2], cs_b[2], mosi[2], result_wr_en[2], busy[2], done[2], overflow[2];
  logic [31:0] result_data[2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      spi_frame_engine #(.CLK_DIV(gi == 0 ? 4 : 2), .CS_GAP(gi == 0 ? 4 : 3)) u_dut (
        .clk(clk), .reset(reset), .start(start[gi]), .num_frames(num_frames[gi]),
        .cmd_word(cmd_word[gi]), .miso(miso[gi]), .fifo_full(fifo_full[gi]),
        .sclk(sclk[gi]), .cs_b(cs_b[gi]), .mosi(mosi[gi]), .result_data(result_data[gi]),
        .result_wr_en(result_wr_en[gi]), .busy(busy[gi]), .done(done[gi]), .overflow(overflow[gi])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  // model: a burst is fully described by its start cycle and latched inputs
  bit           active[2];
  longint       t0[2];
  int           nfm[2];
  logic [15:0]  cmdm[2], respm[2];
  logic [255:0] ffm[2];
  bit           ovm[2];

  // observations used by the literal checks
  int          nwr[2], ndone[2], ncsf[2];
  logic [31:0] last_data[2];
  logic [7:0]  wr_idx[2][$];
  logic        prev_cs[2], prev_sclk[2];
  longint      last_csf_cyc[2], last_done_cyc[2], last_rise[2];
  int          sclk_period[2];
  logic [15:0] mosi_obs[2];

  function automatic int cdf(int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic int gapf(int i);
    return (i == 0) ? 4 : 3;
  endfunction
  function automatic logic [15:0] exp_rx(int i);
`ifdef SPI_LOOPBACK_EN
    return cmdm[i];
`else
    return respm[i];
`endif
  endfunction

  task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cyc=%0d got=%h expected=%h", name, i, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      int cd = cdf(i);
      int p  = 34 * cdf(i) + gapf(i);
      logic e_busy = 1'b0, e_cs = 1'b1, e_sclk = 1'b0, e_wr = 1'b0, e_done = 1'b0;
      logic e_mosi = 1'b0, mosi_chk = 1'b0;
      logic [31:0] e_data = 32'd0;
      if (active[i] && (cyc - t0[i]) > longint'((nfm[i] + 1) * p)) active[i] = 1'b0;
      if (active[i]) begin
        int rel = int'(cyc - t0[i]);
        int k = rel / p;
        int o = rel % p;
        e_busy = 1'b1;
        if (k == nfm[i] + 1) begin
          e_done = 1'b1;
        end else begin
          e_cs = (o < 34 * cd) ? 1'b0 : 1'b1;
          if (o >= cd && o < 33 * cd) e_sclk = (((o - cd) / cd) % 2) == 1;
          if (o < 33 * cd) begin
            mosi_chk = 1'b1;
            e_mosi = cmdm[i][15 - ((o < cd) ? 0 : (o - cd) / (2 * cd))];
          end
          if (o == 34 * cd) begin
            if (ffm[i][k]) ovm[i] = 1'b1;
            else begin
              e_wr = 1'b1;
              e_data = {8'(k), 8'h00, exp_rx(i)};
            end
          end
        end
      end
      chk("busy", i, busy[i], e_busy);
      chk("cs_b", i, cs_b[i], e_cs);
      chk("sclk", i, sclk[i], e_sclk);
      chk("wr_en", i, result_wr_en[i], e_wr);
      chk("done", i, done[i], e_done);
      chk("overflow", i, overflow[i], ovm[i]);
      if (e_wr) chk("data", i, result_data[i], e_data);
      if (mosi_chk) chk("mosi", i, mosi[i], e_mosi);
      // observations
      if (result_wr_en[i]) begin
        nwr[i]++;
        last_data[i] = result_data[i];
        wr_idx[i].push_back(result_data[i][31:24]);
      end
      if (done[i]) begin
        ndone[i]++;
        last_done_cyc[i] = cyc;
      end
      if (prev_cs[i] && !cs_b[i]) begin
        ncsf[i]++;
        last_csf_cyc[i] = cyc;
        last_rise[i] = -1;
      end
      if (sclk[i] && !prev_sclk[i]) begin
        if (last_rise[i] >= 0) sclk_period[i] = int'(cyc - last_rise[i]);
        last_rise[i] = cyc;
        mosi_obs[i] = {mosi_obs[i][14:0], mosi[i]};
      end
      prev_cs[i] = cs_b[i];
      prev_sclk[i] = sclk[i];
    end
  endtask

  // sensor and FIFO stimulus for the cycle just checked
  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      int cd = cdf(i);
      int p  = 34 * cdf(i) + gapf(i);
      miso[i] = 1'($urandom);
      fifo_full[i] = 1'($urandom);
      if (active[i]) begin
        int rel = int'(cyc - t0[i]);
        int k = rel / p;
        int o = rel % p;
        if (k <= nfm[i]) begin
          fifo_full[i] = ffm[i][k];
          if (o >= cd && o < 33 * cd) miso[i] = respm[i][15 - (o - cd) / (2 * cd)];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    drive_inputs();
  endtask

  task automatic pulse_start(int i, int nf, logic [15:0] cmd, logic [15:0] resp, logic [255:0] ff);
    start[i] = 1'b1;
    num_frames[i] = 8'(nf);
    cmd_word[i] = cmd;
    if (!active[i] && !reset) begin
      active[i] = 1'b1;
      t0[i] = cyc + 1;
      nfm[i] = nf;
      cmdm[i] = cmd;
      respm[i] = resp;
      ffm[i] = ff;
    end
    step();
    start[i] = 1'b0;
    num_frames[i] = 8'($urandom);
    cmd_word[i] = 16'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      ovm[i] = 1'b0;
    end
    step();
    for (int i = 0; i < 2; i++) chk("reset_data", i, result_data[i], 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    while ((active[0] || active[1]) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 0, (active[0] || active[1]) ? 1 : 0, 0);
  endtask

  initial begin
    int w, d, c;
    logic [255:0] ff;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; num_frames[i] = 8'd0; cmd_word[i] = 16'd0; miso[i] = 1'b0; fifo_full[i] = 1'b0;
      active[i] = 1'b0; ovm[i] = 1'b0; nwr[i] = 0; ndone[i] = 0; ncsf[i] = 0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; last_rise[i] = -1; sclk_period[i] = 0;
      last_csf_cyc[i] = 0; last_done_cyc[i] = 0; mosi_obs[i] = 16'd0; last_data[i] = 32'd0;
    end
    repeat (2) step();
    do_reset();

    // single frame, A5C3
    w = nwr[0];
    pulse_start(0, 0, 16'hA5C3, 16'hA5C3, '0);
    run_idle(400);
    chk("a5c3_writes", 0, nwr[0] - w, 1);
    chk("a5c3_data", 0, last_data[0], 32'h0000A5C3);
    chk("a5c3_done_delay", 0, 32'(last_done_cyc[0] - last_csf_cyc[0]), 140);

    // 32-frame burst from a fixed-response sensor
    w = nwr[0]; c = ncsf[0];
    pulse_start(0, 31, 16'h1234, 16'h1234, '0);
    run_idle(5000);
    chk("b32_writes", 0, nwr[0] - w, 32);
    chk("b32_last", 0, last_data[0], 32'h1F001234);
    chk("b32_cs_windows", 0, ncsf[0] - c, 32);

    // start pulse mid-burst is ignored
    w = nwr[0]; d = ndone[0];
    pulse_start(0, 5, 16'h5A5A, 16'hC0DE, '0);
    repeat (300) step();
    pulse_start(0, 9, 16'hFFFF, 16'h0000, '0);
    run_idle(1200);
    chk("mid_start_writes", 0, nwr[0] - w, 6);
    chk("mid_start_done", 0, ndone[0] - d, 1);

    // FIFO full during frame 2 of 4
    wr_idx[0].delete();
    ff = '0; ff[2] = 1'b1;
    pulse_start(0, 3, 16'h0F0F, 16'hBEEF, ff);
    run_idle(800);
    chk("ovf_writes", 0, wr_idx[0].size(), 3);
    if (wr_idx[0].size() == 3) begin
      chk("ovf_idx0", 0, wr_idx[0][0], 0);
      chk("ovf_idx1", 0, wr_idx[0][1], 1);
      chk("ovf_idx2", 0, wr_idx[0][2], 3);
    end
    repeat (20) step();
    chk("ovf_sticky", 0, overflow[0], 1);
    do_reset();
    chk("ovf_cleared", 0, overflow[0], 0);

    // reset while shifting
    w = nwr[0]; d = ndone[0];
    pulse_start(0, 2, 16'h3C3C, 16'h1111, '0);
    repeat (19) step();
    chk("abort_in_shift", 0, {cs_b[0], sclk[0]}, 2'b01);
    do_reset();
    chk("abort_cs_b", 0, cs_b[0], 1);
    chk("abort_sclk", 0, sclk[0], 0);
    chk("abort_busy", 0, busy[0], 0);
    repeat (400) step();
    chk("abort_writes", 0, nwr[0] - w, 0);
    chk("abort_done", 0, ndone[0] - d, 0);

    // CLK_DIV=2 instance, 8001
    pulse_start(1, 0, 16'h8001, 16'h8001, '0);
    run_idle(200);
    chk("div2_period", 1, sclk_period[1], 4);
    chk("div2_mosi_bits", 1, mosi_obs[1], 16'h8001);
    chk("div2_data", 1, last_data[1], 32'h00008001);

    // randomized bursts on both instances
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 256; k++) ff[k] = ($urandom % 4) == 0;
        pulse_start(i, int'($urandom % 4), 16'($urandom), 16'($urandom), ff);
        repeat ($urandom % 40) step();
      end
      for (int n = 0; n < 2000 && (active[0] || active[1]); n++) begin
        if (it % 4 == 3 && n == 100) do_reset();
        else if ($urandom % 150 == 0)
          pulse_start(int'($urandom % 2), int'($urandom % 3), 16'($urandom), 16'($urandom), '0);
        else step();
      end
      chk("rand_idle", it, (active[0] || active[1]) ? 1 : 0, 0);
      repeat (5) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
